dmi_arbiter: RTL and testbench

// - Shares one debug-module register bus (DMI target) between two DMI requesters:
//   m0 = JTAG DTM (jtag dmi_*_o/dmi_*_i), m1 = auxiliary debug host.
// - Round-robin grant, one outstanding transaction, per-access timeout.
// - Returns RISC-V DMI op status (0 ok, 2 failed, 3 busy) to the granted requester.

---
 rtl/dmi_arbiter_if.sv | 49 ++++
 rtl/dmi_arbiter.sv | 94 +++++++++
 tb/tb_dmi_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmi_arbiter_if.sv
// dmi_arbiter_if: requester, target and status signals of the two-requester DMI arbiter
interface dmi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_we_i;
    logic              m0_ack_o;
    logic [1:0]        m0_op_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_rdata_valid_o;
    logic              m1_req_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_we_i;
    logic              m1_ack_o;
    logic [1:0]        m1_op_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_rdata_valid_o;
    logic              tgt_req_o;
    logic [ADDR_W-1:0] tgt_addr_o;
    logic [DATA_W-1:0] tgt_wdata_o;
    logic              tgt_we_o;
    logic              tgt_ack_i;
    logic              tgt_err_i;
    logic [DATA_W-1:0] tgt_rdata_i;
    logic [1:0]        grant_o;
    logic              busy_o;
    modport slave (
        input  m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i,
        output m0_ack_o, m0_op_o, m0_rdata_o, m0_rdata_valid_o,
        input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i,
        output m1_ack_o, m1_op_o, m1_rdata_o, m1_rdata_valid_o,
        output tgt_req_o, tgt_addr_o, tgt_wdata_o, tgt_we_o,
        input  tgt_ack_i, tgt_err_i, tgt_rdata_i,
        output grant_o, busy_o
    );
    modport master (
        output m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i,
        input  m0_ack_o, m0_op_o, m0_rdata_o, m0_rdata_valid_o,
        output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i,
        input  m1_ack_o, m1_op_o, m1_rdata_o, m1_rdata_valid_o,
        input  tgt_req_o, tgt_addr_o, tgt_wdata_o, tgt_we_o,
        output tgt_ack_i, tgt_err_i, tgt_rdata_i,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin sharing of one DMI target between two requesters with per-access timeout
module dmi_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic           clk_i,
    input logic           rst_i,
    dmi_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          own;
    logic          pick;
    logic          done;
    logic [1:0]    op_n;
    logic          rd_ok;
    // next owner, completion condition and completion status
    always_comb begin
        pick  = (bus.m0_req_i && bus.m1_req_i) ? !last : bus.m1_req_i;
        done  = bus.tgt_ack_i || (TIMEOUT != 0 && cnt == TO);
        op_n  = bus.tgt_ack_i ? (bus.tgt_err_i ? 2'd2 : 2'd0) : 2'd3;
        rd_ok = bus.tgt_ack_i && !bus.tgt_err_i && !bus.tgt_we_o;
    end
    // arbitration FSM with all outputs registered; last=1 after reset so m0 wins a tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                <= IDLE;
            cnt                  <= '0;
            last                 <= 1'b1;
            own                  <= 1'b0;
            bus.m0_ack_o         <= 1'b0;
            bus.m0_op_o          <= 2'd0;
            bus.m0_rdata_o       <= '0;
            bus.m0_rdata_valid_o <= 1'b0;
            bus.m1_ack_o         <= 1'b0;
            bus.m1_op_o          <= 2'd0;
            bus.m1_rdata_o       <= '0;
            bus.m1_rdata_valid_o <= 1'b0;
            bus.tgt_req_o        <= 1'b0;
            bus.tgt_addr_o       <= '0;
            bus.tgt_wdata_o      <= '0;
            bus.tgt_we_o         <= 1'b0;
            bus.grant_o          <= 2'b00;
            bus.busy_o           <= 1'b0;
        end else begin
            bus.m0_ack_o         <= 1'b0;
            bus.m1_ack_o         <= 1'b0;
            bus.m0_rdata_valid_o <= 1'b0;
            bus.m1_rdata_valid_o <= 1'b0;
            case (state)
                IDLE: if (bus.m0_req_i || bus.m1_req_i) begin
                    state           <= REQ;
                    own             <= pick;
                    cnt             <= '0;
                    bus.tgt_req_o   <= 1'b1;
                    bus.tgt_addr_o  <= pick ? bus.m1_addr_i : bus.m0_addr_i;
                    bus.tgt_wdata_o <= pick ? bus.m1_wdata_i : bus.m0_wdata_i;
                    bus.tgt_we_o    <= pick ? bus.m1_we_i : bus.m0_we_i;
                    bus.grant_o     <= pick ? 2'b10 : 2'b01;
                    bus.busy_o      <= 1'b1;
                end
                REQ: if (done) begin
                    state         <= RESP;
                    last          <= own;
                    bus.tgt_req_o <= 1'b0;
                    if (own) begin
                        bus.m1_ack_o         <= 1'b1;
                        bus.m1_op_o          <= op_n;
                        bus.m1_rdata_valid_o <= rd_ok;
                        if (rd_ok) bus.m1_rdata_o <= bus.tgt_rdata_i;
                    end else begin
                        bus.m0_ack_o         <= 1'b1;
                        bus.m0_op_o          <= op_n;
                        bus.m0_rdata_valid_o <= rd_ok;
                        if (rd_ok) bus.m0_rdata_o <= bus.tgt_rdata_i;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    state       <= IDLE;
                    bus.grant_o <= 2'b00;
                    bus.busy_o  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_dmi_arbiter;
    localparam int TIMEOUT = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   [1:0]  rq;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    bit          we [2];
    bit          last_m1;
    logic [1:0]  mdl_op [2];
    logic [31:0] mdl_rd [2];

    dmi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmi_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int m);
        return m != 0 ? bus.m1_ack_o : bus.m0_ack_o;
    endfunction
    function automatic logic get_rv(input int m);
        return m != 0 ? bus.m1_rdata_valid_o : bus.m0_rdata_valid_o;
    endfunction
    function automatic logic [1:0] get_op(input int m);
        return m != 0 ? bus.m1_op_o : bus.m0_op_o;
    endfunction
    function automatic logic [31:0] get_rd(input int m);
        return m != 0 ? bus.m1_rdata_o : bus.m0_rdata_o;
    endfunction

    task automatic apply();
        bus.m0_req_i = rq[0]; bus.m0_addr_i = ad[0]; bus.m0_wdata_i = wd[0]; bus.m0_we_i = we[0];
        bus.m1_req_i = rq[1]; bus.m1_addr_i = ad[1]; bus.m1_wdata_i = wd[1]; bus.m1_we_i = we[1];
    endtask

    task automatic set_new(input int m, input bit w, input logic [31:0] a, input logic [31:0] d);
        rq[m] = 1'b1; we[m] = w; ad[m] = a; wd[m] = d;
        apply();
    endtask

    task automatic model_reset();
        last_m1 = 1'b1;
        mdl_op[0] = 2'd0; mdl_op[1] = 2'd0;
        mdl_rd[0] = '0;   mdl_rd[1] = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, bus.grant_o, 2'b00);
        chk({tag, "_busy"}, bus.busy_o, 1'b0);
        chk({tag, "_tgt_req"}, bus.tgt_req_o, 1'b0);
        chk({tag, "_acks"}, {bus.m0_ack_o, bus.m1_ack_o, bus.m0_rdata_valid_o, bus.m1_rdata_valid_o}, 4'b0);
    endtask

    // One transaction: ack arrives in REQ cycle d (0 = first); d > TIMEOUT means never.
    task automatic txn(input int d, input bit err, input logic [31:0] rd);
        int o, n, e;
        bit hit, rv;
        logic [1:0] op;
        o   = (rq[0] && rq[1]) ? (last_m1 ? 0 : 1) : (rq[1] ? 1 : 0);
        hit = d <= TIMEOUT;
        n   = hit ? d : TIMEOUT;
        e   = n + 2;
        op  = hit ? (err ? 2'd2 : 2'd0) : 2'd3;
        rv  = hit && !err && !we[o];
        for (int c = 1; c <= e; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("grant", bus.grant_o, o != 0 ? 2'b10 : 2'b01);
                chk("busy", bus.busy_o, 1'b1);
                chk("tgt_req", bus.tgt_req_o, 1'b1);
                chk("tgt_addr", bus.tgt_addr_o, ad[o]);
                chk("tgt_wdata", bus.tgt_wdata_o, wd[o]);
                chk("tgt_we", bus.tgt_we_o, we[o]);
            end
            if (c == e - 1) chk("early_ack", get_ack(o), 1'b0);
            if (c == e) begin
                mdl_op[o] = op;
                if (rv) mdl_rd[o] = rd;
                chk("ack", get_ack(o), 1'b1);
                chk("op", get_op(o), mdl_op[o]);
                chk("rvalid", get_rv(o), rv);
                chk("rdata", get_rd(o), mdl_rd[o]);
                chk("resp_tgt_req", bus.tgt_req_o, 1'b0);
                chk("other_ack", get_ack(1 - o), 1'b0);
                chk("other_op", get_op(1 - o), mdl_op[1 - o]);
                chk("other_rdata", get_rd(1 - o), mdl_rd[1 - o]);
                rq[o] = 1'b0;
                apply();
            end
            bus.tgt_ack_i   = (c - 1 == d) && (c < e);
            bus.tgt_err_i   = err;
            bus.tgt_rdata_i = (c - 1 == d) ? rd : $urandom;
        end
        bus.tgt_ack_i = 1'b0;
        bus.tgt_err_i = 1'b0;
        last_m1 = (o != 0);
        @(negedge clk);
        check_idle("post");
    endtask

    initial begin
        rq = 2'b00;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0; we[0] = 1'b0; we[1] = 1'b0;
        apply();
        bus.tgt_ack_i = 1'b0; bus.tgt_err_i = 1'b0; bus.tgt_rdata_i = '0;
        model_reset();
        repeat (4) @(negedge clk);
        check_idle("rst");
        chk("rst_ops", {bus.m0_op_o, bus.m1_op_o}, 4'b0);
        chk("rst_rdata", {bus.m0_rdata_o, bus.m1_rdata_o}, 64'b0);
        chk("rst_tgt", {bus.tgt_addr_o, bus.tgt_wdata_o, bus.tgt_we_o}, 65'b0);
        rst = 1'b0;
        set_new(0, 1'b1, 32'h0a, 32'h8c);
        txn(0, 1'b0, $urandom);
        set_new(1, 1'b0, 32'h12, $urandom);
        txn(3, 1'b0, 32'h123);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_new(0, 1'b1, $urandom, $urandom);
        set_new(1, 1'b0, $urandom, $urandom);
        for (int k = 0; k < 4; k++) begin
            txn(k, 1'b0, $urandom);
            set_new(last_m1 ? 1 : 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        txn(1, 1'b0, $urandom);
        txn(0, 1'b0, $urandom);
        set_new(0, 1'b0, $urandom, $urandom);
        txn(1, 1'b0, $urandom);
        set_new(1, 1'b0, $urandom, $urandom);
        txn(TIMEOUT, 1'b0, $urandom);
        set_new(0, 1'b1, $urandom, $urandom);
        txn(20, 1'b1, $urandom);
        bus.tgt_ack_i = 1'b1;
        bus.tgt_rdata_i = $urandom;
        @(negedge clk);
        bus.tgt_ack_i = 1'b0;
        check_idle("late_ack");
        @(negedge clk);
        check_idle("late_ack2");
        chk("late_op", bus.m0_op_o, mdl_op[0]);
        set_new(0, 1'b0, $urandom, $urandom);
        txn(2, 1'b1, $urandom);
        for (int k = 0; k < 25; k++) begin
            for (int m = 0; m < 2; m++)
                if (!rq[m] && $urandom_range(0, 1) == 1) set_new(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (rq == 2'b00) set_new(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            txn(int'($urandom_range(0, 11)), $urandom_range(0, 3) == 0, $urandom);
        end
        rq = 2'b00;
        apply();
        set_new(1, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk("mid_tgt_req", bus.tgt_req_o, 1'b1);
        rst = 1'b1;
        rq = 2'b00;
        apply();
        bus.tgt_ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.tgt_ack_i = 1'b0;
        check_idle("mid_rst");
        @(negedge clk);
        check_idle("mid_rst2");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
